// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared datapath types and constants for the multi-cycle CPU.
//               Contents:
//                 stage_state_t - occupancy state of an operand stage register
//                 OPERAND_W     - default operand width in bits
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  // The encoding doubles as the entry count, so it can be driven straight onto
  // the occupancy output.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } stage_state_t;

  localparam int OPERAND_W = 32;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/operand_slot.sv
`default_nettype none
// ============================================================================
// Module      : operand_slot
// Description : One NCH x WIDTH entry register with load enable. On reset,
//               every channel is loaded with RESET_VAL.
//   CLK   in  clock, rising edge
//   rst_n in  asynchronous active-low reset
//   load  in  capture d on the next rising edge
//   d     in  NCH*WIDTH entry to capture
//   q     out NCH*WIDTH held entry
// Revision    : 1.0 - initial release
// ============================================================================
module operand_slot #(
  parameter int               WIDTH     = 32,
  parameter int               NCH       = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                 CLK,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic [NCH*WIDTH-1:0] d,
  output logic [NCH*WIDTH-1:0] q
);

  logic [NCH*WIDTH-1:0] r_q;

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= {NCH{RESET_VAL}};
    end else if (load) begin
      r_q <= d;
    end
  end

  assign q = r_q;

endmodule : operand_slot
`default_nettype wire

// File: rtl/operand_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : operand_stage_reg
// Description : Inter-stage operand register carrying NCH channels of WIDTH
//               bits. MODE 0 provides a valid/ready handshake with a 2-entry
//               skid buffer. MODE 1 is a legacy free-running latch.
//   CLK       in  clock, rising edge
//   rst_n     in  asynchronous active-low reset
//   in_valid  in  upstream presents data
//   in_ready  out stage can accept (decoded from state only)
//   in_data   in  channel k at [k*WIDTH +: WIDTH]
//   flush     in  synchronous discard of all held entries
//   out_valid out out_data holds a valid entry
//   out_ready in  downstream consumes
//   out_data  out head entry, driven directly from the main register
//   occupancy out number of entries held (0..2)
// Revision    : 1.0 - initial release
// ============================================================================
module operand_stage_reg
  import cpu_pkg::*;
#(
  parameter int               WIDTH     = OPERAND_W,
  parameter int               NCH       = 2,
  parameter int               MODE      = 0,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                 CLK,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NCH*WIDTH-1:0] out_data,
  output logic [1:0]           occupancy
);

  logic                 w_main_load;
  logic [NCH*WIDTH-1:0] w_main_d;

  // The main slot always holds the oldest entry and drives out_data directly.
  operand_slot #(
    .WIDTH     (WIDTH),
    .NCH       (NCH),
    .RESET_VAL (RESET_VAL)
  ) u_main (
    .CLK   (CLK),
    .rst_n (rst_n),
    .load  (w_main_load),
    .d     (w_main_d),
    .q     (out_data)
  );

  generate
    if (MODE == 0) begin : g_handshake
      stage_state_t         r_state;
      stage_state_t         w_state_nxt;
      logic                 w_accept;
      logic                 w_take;
      logic                 w_skid_load;
      logic [NCH*WIDTH-1:0] w_skid_q;

      operand_slot #(
        .WIDTH     (WIDTH),
        .NCH       (NCH),
        .RESET_VAL (RESET_VAL)
      ) u_skid (
        .CLK   (CLK),
        .rst_n (rst_n),
        .load  (w_skid_load),
        .d     (in_data),
        .q     (w_skid_q)
      );

      always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
          r_state <= ST_EMPTY;
        end else begin
          r_state <= w_state_nxt;
        end
      end

      // Handshake outputs decode the state register only, so there is no
      // combinational path from out_ready to in_ready.
      assign in_ready  = (r_state != ST_TWO);
      assign out_valid = (r_state != ST_EMPTY);
      assign occupancy = r_state;

      assign w_accept = in_valid && in_ready;
      assign w_take   = out_valid && out_ready;

      always_comb begin
        w_state_nxt = r_state;
        w_main_load = 1'b0;
        w_main_d    = in_data;
        w_skid_load = 1'b0;
        if (flush) begin
          // Held entries and any accepted upstream entry are dropped; data
          // registers keep their old contents since out_valid goes low.
          w_state_nxt = ST_EMPTY;
        end else begin
          case (r_state)
            ST_EMPTY: begin
              if (w_accept) begin
                w_state_nxt = ST_ONE;
                w_main_load = 1'b1;
              end
            end
            ST_ONE: begin
              if (w_accept && w_take) begin
                w_main_load = 1'b1;
              end else if (w_accept) begin
                w_state_nxt = ST_TWO;
                w_skid_load = 1'b1;
              end else if (w_take) begin
                w_state_nxt = ST_EMPTY;
              end
            end
            ST_TWO: begin
              if (w_take) begin
                w_state_nxt = ST_ONE;
                w_main_load = 1'b1;
                w_main_d    = w_skid_q;
              end
            end
            default: begin
              w_state_nxt = ST_EMPTY;
            end
          endcase
        end
      end
    end else begin : g_legacy
      logic r_valid;

      always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
          r_valid <= 1'b0;
        end else begin
          r_valid <= in_valid && !flush;
        end
      end

      assign in_ready    = 1'b1;
      assign out_valid   = r_valid;
      assign occupancy   = {1'b0, r_valid};
      assign w_main_load = 1'b1;
      assign w_main_d    = in_data;
    end
  endgenerate

endmodule : operand_stage_reg
`default_nettype wire

// File: tb/tb_operand_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_operand_stage_reg
// Description : Self-checking bench for operand_stage_reg. One instance in
//               handshake mode and one in legacy mode, compared every cycle
//               against a queue-based model, plus directed literal checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_operand_stage_reg;

  localparam int W   = 32;
  localparam int NCH = 2;
  localparam int DW  = W * NCH;

  logic          CLK = 1'b0;
  logic          rst_n = 1'b0;

  // handshake instance
  logic          in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready, out_valid;
  logic [DW-1:0] out_data;
  logic [1:0]    occupancy;

  // legacy instance
  logic          in_valid_l = 1'b0, flush_l = 1'b0, out_ready_l = 1'b0;
  logic [DW-1:0] in_data_l = '0;
  logic          in_ready_l, out_valid_l;
  logic [DW-1:0] out_data_l;
  logic [1:0]    occupancy_l;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] q[$];     // model FIFO contents, head = q[0]
  logic [DW-1:0] got[$];   // entries observed leaving the DUT
  int            maxocc = 0;
  logic          m_lvalid = 1'b0;
  logic [DW-1:0] m_ldata = '0;

  always #5 CLK = ~CLK;

  operand_stage_reg #(.WIDTH(W), .NCH(NCH), .MODE(0), .RESET_VAL('0)) dut (
    .CLK(CLK), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .occupancy(occupancy)
  );

  operand_stage_reg #(.WIDTH(W), .NCH(NCH), .MODE(1), .RESET_VAL('0)) dut_l (
    .CLK(CLK), .rst_n(rst_n), .in_valid(in_valid_l), .in_ready(in_ready_l),
    .in_data(in_data_l), .flush(flush_l), .out_valid(out_valid_l),
    .out_ready(out_ready_l), .out_data(out_data_l), .occupancy(occupancy_l)
  );

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] mk(input logic [W-1:0] v);
    return {v ^ 32'hFFFF_0000, v};
  endfunction

  // Compare process and model: outputs are checked mid-cycle, then the model
  // advances using the inputs that will be present at the next rising edge.
  always @(negedge CLK) begin
    if (!rst_n) begin
      chk("rst_out_valid", DW'(out_valid), 0);
      chk("rst_in_ready", DW'(in_ready), 1);
      chk("rst_occupancy", DW'(occupancy), 0);
      chk("rst_out_data", out_data, '0);
      chk("rst_l_out_valid", DW'(out_valid_l), 0);
      chk("rst_l_out_data", out_data_l, '0);
      q.delete();
      m_lvalid = 1'b0;
      m_ldata  = '0;
    end else begin
      bit acc, tk;
      chk("occupancy", DW'(occupancy), DW'(q.size()));
      chk("in_ready", DW'(in_ready), DW'(q.size() < 2));
      chk("out_valid", DW'(out_valid), DW'(q.size() > 0));
      if (q.size() > 0) chk("out_data", out_data, q[0]);
      if (out_valid && out_ready) got.push_back(out_data);
      if (int'(occupancy) > maxocc) maxocc = int'(occupancy);
      acc = in_valid && (q.size() < 2);
      tk  = (q.size() > 0) && out_ready;
      if (flush) begin
        q.delete();
      end else begin
        if (tk) void'(q.pop_front());
        if (acc) q.push_back(in_data);
      end

      chk("l_out_valid", DW'(out_valid_l), DW'(m_lvalid));
      chk("l_out_data", out_data_l, m_ldata);
      chk("l_in_ready", DW'(in_ready_l), 1);
      chk("l_occupancy", DW'(occupancy_l), DW'({1'b0, m_lvalid}));
      m_ldata  = in_data_l;
      m_lvalid = in_valid_l && !flush_l;
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    // Reset with upstream presenting data: nothing may be captured.
    in_valid = 1'b1;
    in_data  = 64'hDEAD_BEEF_0000_0001;
    repeat (3) tick();
    chk("reset_hold_out_data", out_data, '0);
    chk("reset_hold_occ", DW'(occupancy), 0);

    rst_n   = 1'b1;
    in_data = 64'h1;
    tick();
    in_valid = 1'b0;
    chk("first_accept_valid", DW'(out_valid), 1);
    chk("first_accept_data", out_data, 64'h1);
    out_ready = 1'b1;
    tick();
    chk("first_drain_occ", DW'(occupancy), 0);

    // Streaming 1..8 with out_ready held high.
    got.delete();
    maxocc = 0;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1;
      in_data  = mk(W'(i));
      tick();
    end
    in_valid = 1'b0;
    repeat (3) tick();
    chk("stream_count", DW'(got.size()), 8);
    for (int i = 0; i < 8 && i < got.size(); i++)
      chk("stream_order", got[i], mk(W'(i + 1)));
    chk("stream_maxocc", DW'(maxocc), 1);

    // Backpressure: A, B accepted, C held upstream until space opens.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = mk(32'h11);
    tick();
    chk("bp_occ1", DW'(occupancy), 1);
    in_data = mk(32'h22);
    tick();
    chk("bp_occ2", DW'(occupancy), 2);
    chk("bp_in_ready_low", DW'(in_ready), 0);
    in_data = mk(32'h33);
    tick();
    chk("bp_still_two", DW'(occupancy), 2);
    chk("bp_head_A", out_data, mk(32'h11));
    got.delete();
    out_ready = 1'b1;
    tick();
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    chk("bp_count", DW'(got.size()), 3);
    if (got.size() == 3) begin
      chk("bp_A", got[0], mk(32'h11));
      chk("bp_B", got[1], mk(32'h22));
      chk("bp_C", got[2], mk(32'h33));
    end

    // Flush while full, with upstream presenting data.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = mk(32'h21);
    tick();
    in_data = mk(32'h22);
    tick();
    chk("fl_pre_occ", DW'(occupancy), 2);
    flush   = 1'b1;
    in_data = mk(32'h23);
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("fl_occ", DW'(occupancy), 0);
    chk("fl_out_valid", DW'(out_valid), 0);
    chk("fl_in_ready", DW'(in_ready), 1);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = mk(32'h55);
    tick();
    in_valid = 1'b0;
    got.delete();
    repeat (2) tick();
    chk("fl_next_count", DW'(got.size()), 1);
    if (got.size() > 0) chk("fl_next_data", got[0], mk(32'h55));

    // Simultaneous accept and take in ONE.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = mk(32'hAA);
    tick();
    got.delete();
    in_data   = mk(32'hBB);
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("sim_occ", DW'(occupancy), 1);
    chk("sim_data", out_data, mk(32'hBB));
    chk("sim_taken", DW'(got.size()), 1);
    if (got.size() > 0) chk("sim_taken_AA", got[0], mk(32'hAA));
    repeat (2) tick();

    // Legacy mode: free-running capture, out_ready ignored.
    out_ready_l = 1'b0;
    in_valid_l  = 1'b1;
    in_data_l   = 64'd5;
    tick();
    chk("leg_5", out_data_l, 64'd5);
    in_data_l = 64'd6;
    tick();
    chk("leg_6", out_data_l, 64'd6);
    in_data_l = 64'd7;
    tick();
    chk("leg_7", out_data_l, 64'd7);
    chk("leg_valid", DW'(out_valid_l), 1);
    chk("leg_ready", DW'(in_ready_l), 1);
    flush_l = 1'b1;
    tick();
    flush_l = 1'b0;
    chk("leg_flush_valid", DW'(out_valid_l), 0);
    tick();
    chk("leg_after_flush_valid", DW'(out_valid_l), 1);
    in_valid_l = 1'b0;
    repeat (2) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_operand_stage_reg
`default_nettype wire

// File: doc/operand_stage_reg.md
# operand_stage_reg

Parametrised inter-stage operand register for the multi-cycle CPU datapath. It replaces the single free-running datapath latches (register-file read latches, ALU result latch) with one block. The block carries NCH operand channels of WIDTH bits and has a valid/ready handshake, a 2-entry skid buffer, and a synchronous flush. A legacy mode keeps the old behaviour: the input is captured every clock.

## Interface
- WIDTH, 32, bits per channel
- NCH, 2, number of operand channels carried in lockstep
- MODE, 0, 0 = handshake with skid buffer; 1 = legacy free-running latch
- RESET_VAL, 0, WIDTH-bit value loaded into every channel on reset

- CLK  in  1  single clock, all state updates on rising edge
- Reset  in  1  asynchronous, active-low reset
- in_valid  in  1  upstream presents data
- in_ready  out  1  block can accept; registered, derived from state only
- in_data  in  NCH*WIDTH  channel k at bits [k*WIDTH +: WIDTH]
- flush  in  1  synchronous discard of all held entries
- out_valid  out  1  out_data holds a valid entry
- out_ready  in  1  downstream consumes
- out_data  out  NCH*WIDTH  head entry, driven directly from the main register
- occupancy  out  2  entries held: 0, 1 or 2

## Operation
- An accept occurs when in_valid && in_ready. A take occurs when out_valid && out_ready.
- MODE 0 state machine:
  - States are EMPTY (0 entries), ONE (main full), TWO (main and skid full).
  - EMPTY + accept -> ONE; main <= in_data.
  - ONE + accept + take -> ONE; main <= in_data.
  - ONE + accept only -> TWO; skid <= in_data.
  - ONE + take only -> EMPTY.
  - TWO + take -> ONE; main <= skid. No accept is possible in TWO because in_ready = 0.
  - Otherwise the state and the data registers hold.
- Output decode: in_ready = (state != TWO). out_valid = (state != EMPTY). occupancy encodes the state directly.
- flush has highest priority. The next state is EMPTY. main and skid keep their contents, and out_data is don't-care while out_valid = 0.
  - Upstream data presented in the flush cycle is accepted and discarded; in_ready is high unless the state is TWO.
  - A take in the flush cycle still completes: downstream sees the entry that was held before the flush.
- MODE 1:
  - main <= in_data every cycle. out_valid <= in_valid, registered.
  - in_ready is tied to 1. skid is unused. occupancy = {1'b0, out_valid}. flush clears out_valid to 0.
  - out_ready is ignored.
- Channels never shift independently; all NCH channels move together.

## Timing
- Reset asserted, asynchronously: state = EMPTY, main = skid = {NCH{RESET_VAL}}.
  - Outputs during reset: out_valid = 0, in_ready = 1, occupancy = 0, out_data = {NCH{RESET_VAL}}.
- Reset deassertion is taken synchronously. The first accept is possible on the first rising edge after release.
- Latency: data accepted at edge N appears on out_data with out_valid = 1 after edge N. Downstream can take it at edge N+1.
- Throughput: 1 entry per cycle in steady state when out_ready stays high. The skid is never used in that case.
- out_ready may drop while in_ready is high: one extra entry lands in skid, and in_ready falls after that edge. No combinational path runs from out_ready to in_ready.
- Ordering is strict FIFO. main always holds the older entry.
- If Reset is asserted mid-transfer, any held entries are lost without signalling.

## Structure
- Shared package cpu_pkg gets:
  - the enum typedef stage_state_t {ST_EMPTY = 2'd0, ST_ONE = 2'd1, ST_TWO = 2'd2};
  - the constant OPERAND_W = 32.
- One sub-module, operand_slot: a WIDTH*NCH register with load enable and an async active-low reset to the replicated RESET_VAL.
  - Instantiated twice, for main and skid. In MODE 1 only main is instantiated.
- The next-state and load-select logic stay in the top module.

## Test plan
- Reset: hold Reset = 0 with in_valid = 1 and in_data = 64'hDEAD_BEEF_0000_0001 -> out_valid = 0, in_ready = 1, occupancy = 0, out_data = 0 throughout. After release, the first accept of 64'h1 appears on out_data one cycle later.
- Streaming, MODE 0, NCH = 2, WIDTH = 32: out_ready = 1, push 1..8 on consecutive cycles -> out_data yields 1..8 in order, one per cycle starting the cycle after the first push, and occupancy never exceeds 1.
- Backpressure: push A = 32'h11, B = 32'h22, C = 32'h33 with out_ready = 0 -> occupancy 1 then 2, in_ready = 0 after B, and C is held upstream. Raising out_ready drains A, then B, then C with no loss or duplication.
- Flush in TWO with in_valid = 1: occupancy becomes 0 next cycle, out_valid = 0, in_ready = 1. A following push of 32'h55 becomes the next output, not the flushed data.
- Simultaneous accept and take in ONE, holding 32'hAA while pushing 32'hBB -> the take returns AA, the next cycle shows BB, and occupancy stays 1.
- MODE 1: drive in_data = 5, 6, 7 on successive cycles with in_valid = 1 and out_ready = 0 -> out_data = 5, 6, 7 each one cycle later, in_ready always 1. flush drops out_valid for one cycle only.
